// File: rtl/csa_pipe_param.sv
// csa_pipe_param: pipelined carry-select adder/subtractor with valid/ready flow control
module csa_pipe_param #(
   parameter int WIDTH  = 64,
   parameter int GROUP  = 8,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             cin,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             crout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int NG  = WIDTH / GROUP;
   localparam int GPS = NG / STAGES;
   localparam int L   = STAGES - 1;

   logic [WIDTH-1:0] a_d [STAGES];
   logic [WIDTH-1:0] b_d [STAGES];
   logic [WIDTH-1:0] s_in [STAGES];
   logic [WIDTH-1:0] s_d [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_in [STAGES];
   logic             c_d [STAGES];
   logic             c_q [STAGES];
   logic             v_d [STAGES];
   logic             v_q [STAGES];
   logic [GROUP:0]   p0 [NG];
   logic [GROUP:0]   p1 [NG];
   logic             stall;

   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = v_q[L];
   assign sum       = s_q[L];
   assign crout     = c_q[L];
   assign ovf       = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) & (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

   // Slice inputs: slice 0 takes the ports (subtract folded into the operand and carry), later slices take the previous boundary
   always_comb begin
      a_d[0]  = op1;
      b_d[0]  = sub ? ~op2 : op2;
      s_in[0] = '0;
      c_in[0] = sub ? ~cin : cin;
      v_d[0]  = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_d[k]  = a_q[k-1];
         b_d[k]  = b_q[k-1];
         s_in[k] = s_q[k-1];
         c_in[k] = c_q[k-1];
         v_d[k]  = v_q[k-1];
      end
   end

   for (genvar g = 0; g < NG; g++) begin : grp
      localparam int K = g / GPS;
      assign p0[g] = {1'b0, a_d[K][g*GROUP +: GROUP]} + {1'b0, b_d[K][g*GROUP +: GROUP]};
      assign p1[g] = {1'b0, a_d[K][g*GROUP +: GROUP]} + {1'b0, b_d[K][g*GROUP +: GROUP]} + (GROUP+1)'(1);
   end

   // Carry-select chain: the incoming group carry picks between the precomputed cin=0 and cin=1 results
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         s_d[k] = s_in[k];
         c_d[k] = c_in[k];
         for (int j = 0; j < GPS; j++) begin
            s_d[k][(k*GPS+j)*GROUP +: GROUP] = c_d[k] ? p1[k*GPS+j][GROUP-1:0] : p0[k*GPS+j][GROUP-1:0];
            c_d[k] = c_d[k] ? p1[k*GPS+j][GROUP] : p0[k*GPS+j][GROUP];
         end
      end
   end

   // Slice boundary registers advance together unless the output is stalled; reset overrides both
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
            v_q[k] <= v_d[k];
         end
      end
   end
endmodule

// File: tb/tb_csa_pipe_param.sv
// tb_csa_pipe_param: reference-model checking of csa_pipe_param across four parameter sets
module tb_csa_pipe_param;
   typedef struct packed {
      logic [63:0] s;
      logic        c;
      logic        o;
      logic [31:0] due;
      logic        lit;
      logic [63:0] ls;
      logic        lc;
      logic        lo;
   } exp_t;

   logic clk = 1'b0;
   int   to_err = 0;

   always #5 clk = ~clk;

   // Reference adder in plain integer arithmetic: returns {ovf, crout, sum}
   function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb);
      logic [65:0]        ua, ub, uc, u;
      logic signed [65:0] sa, sv, sc, r, lim;
      logic               cr;
      ua  = {2'b0, a};
      ub  = {2'b0, b};
      uc  = {65'b0, ci};
      lim = 66'sd1 <<< (w - 1);
      sa  = $signed(ua);
      if (a[w-1]) sa = sa - (lim <<< 1);
      sv  = $signed(ub);
      if (b[w-1]) sv = sv - (lim <<< 1);
      sc  = $signed(uc);
      if (sb) begin
         u  = ua - ub - uc;
         cr = ua >= ub + uc;
         r  = sa - sv - sc;
      end else begin
         u  = ua + ub + uc;
         cr = u[w];
         r  = sa + sv + sc;
      end
      return {r >= lim || r < -lim, cr, u[63:0] & ({64{1'b1}} >> (64 - w))};
   endfunction

   for (genvar c = 0; c < 4; c++) begin : cfg
      localparam int W = c == 3 ? 32 : 64;
      localparam int G = c == 3 ? 4 : 8;
      localparam int S = c == 1 ? 1 : c == 2 ? 4 : 2;
      localparam logic [63:0] M = {64{1'b1}} >> (64 - W);

      logic         reset, in_valid, in_ready, cin, sub, crout, ovf, out_valid, out_ready;
      logic [W-1:0] op1, op2, sum;
      logic         drv_lit = 1'b0, drv_lc = 1'b0, drv_lo = 1'b0, drv_end = 1'b0;
      logic [63:0]  drv_ls = '0;
      logic [65:0]  r;
      logic [31:0]  adv = '0;
      exp_t         q[$];
      bit           exp_v = 1'b0, rst_prev = 1'b0, done = 1'b0;
      int           n_chk = 0, n_err = 0;

      csa_pipe_param #(.WIDTH(W), .GROUP(G), .STAGES(S)) dut (
         .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
         .op1(op1), .op2(op2), .cin(cin), .sub(sub), .sum(sum), .crout(crout),
         .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
      );

      task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
         n_chk++;
         if (a !== e) begin
            n_err++;
            $display("FAIL cfg%0d %s: got %h expected %h", c, n, a, e);
         end
      endtask

      // Check outputs against the model, then advance the model as the coming edge will
      always @(negedge clk) begin
         exp_v = q.size() > 0 && q[0].due <= adv;
         chk("out_valid", 64'(out_valid), 64'(exp_v));
         chk("in_ready", 64'(in_ready), 64'(!(exp_v && !out_ready)));
         if (rst_prev) begin
            chk("reset_sum", 64'(sum), 64'd0);
            chk("reset_crout", 64'(crout), 64'd0);
            chk("reset_ovf", 64'(ovf), 64'd0);
         end
         if (exp_v) begin
            chk("sum", 64'(sum), q[0].s);
            chk("crout", 64'(crout), 64'(q[0].c));
            chk("ovf", 64'(ovf), 64'(q[0].o));
            if (q[0].lit) begin
               chk("model_vs_literal", q[0].s, q[0].ls);
               chk("literal_sum", 64'(sum), q[0].ls);
               chk("literal_crout", 64'(crout), 64'(q[0].lc));
               chk("literal_ovf", 64'(ovf), 64'(q[0].lo));
            end
         end
         if (drv_end && !done) begin
            chk("drained", 64'(q.size()), 64'd0);
            done = 1'b1;
         end
         if (reset) begin
            q.delete();
            rst_prev = 1'b1;
         end else begin
            rst_prev = 1'b0;
            if (!(exp_v && !out_ready)) begin
               if (exp_v) void'(q.pop_front());
               adv++;
               if (in_valid) begin
                  r = ref_add(W, 64'(op1), 64'(op2), cin, sub);
                  q.push_back('{s: r[63:0], c: r[64], o: r[65], due: 32'(adv + S - 1),
                                lit: drv_lit, ls: drv_ls, lc: drv_lc, lo: drv_lo});
               end
            end
         end
      end

      task automatic send(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb,
                          input logic lit, input logic [63:0] ls, input logic lc, input logic lo);
         op1 = a[W-1:0];
         op2 = b[W-1:0];
         cin = ci;
         sub = sb;
         in_valid = 1'b1;
         drv_lit = lit;
         drv_ls = ls;
         drv_lc = lc;
         drv_lo = lo;
         @(negedge clk);
         for (int t = 0; !in_ready; t++) begin
            if (t > 100) begin
               $display("FAIL cfg%0d accept: in_ready stuck at 0, expected 1 within 100 cycles", c);
               $fatal(1);
            end
            @(negedge clk);
         end
         @(posedge clk);
         #1;
      endtask

      task automatic idle(input int n);
         in_valid = 1'b0;
         drv_lit = 1'b0;
         repeat (n) @(posedge clk);
         #1;
      endtask

      task automatic send_rand();
         send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 1'($urandom_range(1)),
              1'b0, 64'd0, 1'b0, 1'b0);
      endtask

      initial begin
         reset = 1'b1;
         in_valid = 1'b0;
         op1 = '0;
         op2 = '0;
         cin = 1'b0;
         sub = 1'b0;
         out_ready = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b0;
         send(64'h1234_5678_90AB_CDEF & M, 64'h5555_5555_5555_DDDD & M, 1'b0, 1'b0, 1'b1, 64'h6789_ABCD_E601_ABCC & M, 1'b0, 1'b0);
         send(M, 64'd0, 1'b1, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
         idle(1);
         send(M >> 1, 64'd1, 1'b0, 1'b0, 1'b1, 64'd1 << (W - 1), 1'b0, 1'b1);
         send(64'd5, 64'd7, 1'b0, 1'b1, 1'b1, M - 64'd1, 1'b0, 1'b0);
         send(64'd7, 64'd5, 1'b0, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
         send(64'd3, 64'd4, 1'b1, 1'b1, 1'b1, M - 64'd1, 1'b0, 1'b0);
         send(64'd1 << (W - 1), 64'd1, 1'b0, 1'b1, 1'b1, M >> 1, 1'b1, 1'b1);
         idle(S + 2);
         fork
            for (int i = 0; i < 10; i++) send_rand();
            begin
               repeat (4) @(posedge clk);
               #1 out_ready = 1'b0;
               repeat (3) @(posedge clk);
               #1 out_ready = 1'b1;
            end
         join
         idle(S + 2);
         for (int i = 0; i < S; i++) send_rand();
         reset = 1'b1;
         out_ready = 1'b0;
         @(posedge clk);
         #1;
         reset = 1'b0;
         out_ready = 1'b1;
         idle(2);
         send(64'hDEAD_BEEF_0123_4567 & M, 64'h0F0F_F0F0_8888_7777 & M, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
         idle(S + 2);
         drv_end = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 20000; i++) begin
         if (cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) break;
         @(posedge clk);
      end
      if (!(cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done)) begin
         $display("FAIL timeout: done flags %b%b%b%b, expected 1111", cfg[0].done, cfg[1].done, cfg[2].done, cfg[3].done);
         to_err = 1;
      end
      $display("Simulation finished: %0d checks, %0d errors",
               cfg[0].n_chk + cfg[1].n_chk + cfg[2].n_chk + cfg[3].n_chk,
               cfg[0].n_err + cfg[1].n_err + cfg[2].n_err + cfg[3].n_err + to_err);
      $finish;
   end
endmodule
